// File: rtl/lane_seg_div_pkg.sv
// lane_seg_div_pkg: widths, FSM states and saturation limits shared by the lane_seg divider
package lane_seg_div_pkg;
  localparam int DIV_W = 27;
  localparam int DVS_W = 11;
  localparam int QUO_W = 16;
  localparam int QUOT_MAX = 32767;
  localparam int QUOT_MIN = -32768;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/lane_seg_div_fix.sv
// lane_seg_div_fix: sign restore, optional rounding (LANE_SEG_DIV_ROUND_EN), saturation and flags
module lane_seg_div_fix
  import lane_seg_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_W,
  parameter int DIVISOR_WIDTH  = DVS_W,
  parameter int QUOT_WIDTH     = QUO_W
) (
  input  logic                      neg,
  input  logic [DIVIDEND_WIDTH-1:0] mag,
  input  logic [DIVISOR_WIDTH:0]    rem,
  input  logic [DIVISOR_WIDTH-1:0]  div,
  output logic [QUOT_WIDTH-1:0]     quot,
  output logic [DIVISOR_WIDTH:0]    remd,
  output logic                      dz,
  output logic                      ovf
);
  logic                           rnd;
  logic [DIVIDEND_WIDTH:0]        qmag;
  logic signed [DIVISOR_WIDTH+1:0] rs;
  always_comb begin
    dz = div == '0;
`ifdef LANE_SEG_DIV_ROUND_EN
    rnd = !dz && ({rem, 1'b0} >= {2'b0, div});
`else
    rnd = 1'b0;
`endif
    qmag = {1'b0, mag} + {{DIVIDEND_WIDTH{1'b0}}, rnd};
    // rounding up one step moves the remainder by one divisor toward the other sign
    rs = {1'b0, rem} - (rnd ? {2'b0, div} : '0);
    ovf = !dz && (neg ? qmag > (DIVIDEND_WIDTH+1)'(-QUOT_MIN) : qmag > (DIVIDEND_WIDTH+1)'(QUOT_MAX));
    quot = (dz || ovf) ? (neg ? QUOT_WIDTH'(QUOT_MIN) : QUOT_WIDTH'(QUOT_MAX))
                       : (neg ? -qmag[QUOT_WIDTH-1:0] : qmag[QUOT_WIDTH-1:0]);
    remd = dz ? '0 : (neg ? (DIVISOR_WIDTH+1)'(-rs) : (DIVISOR_WIDTH+1)'(rs));
  end
endmodule

// File: rtl/lane_seg_top_div_27s_11ns_16s_seq.sv
// lane_seg_top_div_27s_11ns_16s_seq: restoring signed/unsigned divider, one quotient bit per cycle
// Rounding selected by LANE_SEG_DIV_ROUND_EN inside lane_seg_div_fix.
module lane_seg_top_div_27s_11ns_16s_seq
  import lane_seg_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_W,
  parameter int DIVISOR_WIDTH  = DVS_W,
  parameter int QUOT_WIDTH     = QUO_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [QUOT_WIDTH-1:0]     quotient,
  output logic [DIVISOR_WIDTH:0]    remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);
  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] mag_q, mag_d;
  logic [RW-1:0]             rem_q, rem_d, sh, remo_q, remo_d, fix_rem;
  logic [DIVISOR_WIDTH-1:0]  div_q, div_d;
  logic [QUOT_WIDTH-1:0]     quot_q, quot_d, fix_quot;
  logic neg_q, neg_d, s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic dz_q, dz_d, ovf_q, ovf_d, fix_dz, fix_ovf, ge, acc, load;

  assign acc = s_valid && s_ready_q;
  assign sh  = {rem_q[DIVISOR_WIDTH-1:0], mag_q[DIVIDEND_WIDTH-1]};
  assign ge  = sh >= {1'b0, div_q};

  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      neg_q     <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      quot_q    <= '0;
      remo_q    <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mag_q doubles as the quotient shift register: magnitude bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    neg_d = neg_q;
    mag_d = mag_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && acc) begin
      neg_d = dividend[DIVIDEND_WIDTH-1];
      mag_d = neg_d ? -dividend : dividend;
      rem_d = '0;
      div_d = divisor;
      cnt_d = CW'(DIVIDEND_WIDTH - 1);
    end else if (state_q == CALC) begin
      rem_d = ge ? sh - {1'b0, div_q} : sh;
      mag_d = {mag_q[DIVIDEND_WIDTH-2:0], ge};
      cnt_d = cnt_q - CW'(1);
    end
  end

  lane_seg_div_fix #(
    .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
    .DIVISOR_WIDTH (DIVISOR_WIDTH),
    .QUOT_WIDTH    (QUOT_WIDTH)
  ) u_fix (
    .neg (neg_d),
    .mag (mag_d),
    .rem (rem_d),
    .div (div_d),
    .quot(fix_quot),
    .remd(fix_rem),
    .dz  (fix_dz),
    .ovf (fix_ovf)
  );

  // s_ready waits a full IDLE cycle after a result leaves, so there is no same-cycle re-accept
  always_comb begin
    load      = state_d == DONE && state_q != DONE;
    s_ready_d = state_q == IDLE && state_d == IDLE;
    m_valid_d = state_d == DONE;
    quot_d    = load ? fix_quot : quot_q;
    remo_d    = load ? fix_rem : remo_q;
    dz_d      = load ? fix_dz : dz_q;
    ovf_d     = load ? fix_ovf : ovf_q;
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;
endmodule
